// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack core: FSM states, C-instruction
// field positions and the jump-condition helper.
package hack_pkg;

  typedef enum logic [1:0] {
    DECODE = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    HALT   = 2'd3
  } state_e;

  localparam int C_A  = 12;
  localparam int C_ZX = 11;
  localparam int C_NX = 10;
  localparam int C_ZY = 9;
  localparam int C_NY = 8;
  localparam int C_F  = 7;
  localparam int C_NO = 6;
  localparam int C_DA = 5;
  localparam int C_DD = 4;
  localparam int C_DM = 3;

  localparam int J_LT = 2;
  localparam int J_EQ = 1;
  localparam int J_GT = 0;

  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    return (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zx/nx/zy/ny/f/no on a WIDTH-bit datapath.
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] res;

  always_comb begin
    xs = zx ? '0 : x;
    if (nx) xs = ~xs;
    ys = zy ? '0 : y;
    if (ny) ys = ~ys;
    res = f ? (xs + ys) : (xs & ys);
    if (no) res = ~res;
  end

  assign out = res;
  assign zr  = (res == '0);
  assign ng  = res[WIDTH-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: one-cycle register ops, handshaked memory reads and
// writes, and a terminal HALT state entered on a jump to itself.
module hack_cpu_mc
  import hack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 15,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0] inM,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] outM,
  output logic             writeM,
  output logic             readM,
  output logic [AW-1:0]    addressM,
  output logic [AW-1:0]    pc,
  output logic             halted,
  output logic [CNT_W-1:0] retire_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  logic             is_c, use_m, dst_a, dst_d, dst_m;
  logic [2:0]       jbits;
  logic [WIDTH-1:0] alu_y, alu_out;
  logic             alu_zr, alu_ng;
  logic             commit, jump, res_zr, res_ng;
  logic [WIDTH-1:0] res;
  logic [AW-1:0]    pc_inc;

  assign is_c   = instruction[WIDTH-1];
  assign use_m  = instruction[C_A];
  assign dst_a  = instruction[C_DA];
  assign dst_d  = instruction[C_DD];
  assign dst_m  = instruction[C_DM];
  assign jbits  = instruction[J_LT:J_GT];
  assign alu_y  = use_m ? inM : a_q;
  assign pc_inc = pc_q + AW'(1);

  hack_alu #(.WIDTH(WIDTH)) u_alu (
    .x  (d_q),
    .y  (alu_y),
    .zx (instruction[C_ZX]),
    .nx (instruction[C_NX]),
    .zy (instruction[C_ZY]),
    .ny (instruction[C_NY]),
    .f  (instruction[C_F]),
    .no (instruction[C_NO]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= DECODE;
      a_q      <= '0;
      d_q      <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      d_q      <= d_d;
      wdata_q  <= wdata_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    d_d      = d_q;
    wdata_d  = wdata_q;
    pc_d     = pc_q;
    retire_d = retire_q;
    commit   = 1'b0;
    jump     = 1'b0;
    res      = alu_out;
    res_zr   = alu_zr;
    res_ng   = alu_ng;

    case (state_q)
      DECODE: begin
        if (!is_c) begin
          commit = 1'b1;
        end else if (use_m) begin
          state_d = READ;
        end else if (dst_m) begin
          wdata_d = alu_out;
          state_d = WRITE;
        end else begin
          commit = 1'b1;
        end
      end
      READ: begin
        if (mem_ready) begin
          if (dst_m) begin
            wdata_d = alu_out;
            state_d = WRITE;
          end else begin
            commit = 1'b1;
          end
        end
      end
      // inM may no longer be valid here, so the latched result drives the commit
      WRITE: begin
        if (mem_ready) begin
          commit = 1'b1;
          res    = wdata_q;
          res_zr = (wdata_q == '0);
          res_ng = wdata_q[WIDTH-1];
        end
      end
      default: ;
    endcase

    if (commit) begin
      retire_d = retire_q + CNT_W'(1);
      state_d  = DECODE;
      pc_d     = pc_inc;
      if (!is_c) begin
        a_d = {1'b0, instruction[WIDTH-2:0]};
      end else begin
        if (dst_a) a_d = res;
        if (dst_d) d_d = res;
        jump = jump_taken(jbits, res_zr, res_ng);
        if (jump) begin
          pc_d = a_q[AW-1:0];
          if (a_q[AW-1:0] == pc_q) state_d = HALT;
        end
      end
    end
  end

  assign readM        = (state_q == READ);
  assign writeM       = (state_q == WRITE);
  assign outM         = (state_q == WRITE) ? wdata_q : '0;
  assign addressM     = a_q[AW-1:0];
  assign pc           = pc_q;
  assign halted       = (state_q == HALT);
  assign retire_count = retire_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Self-checking bench for hack_cpu_mc: table of ALU/memory vectors plus
// hand-written sequences for waits, jumps, halt and asynchronous reset.
module tb_hack_cpu_mc;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic        mem_ready;
  logic [15:0] outM;
  logic        writeM;
  logic        readM;
  logic [14:0] addressM;
  logic [14:0] pc;
  logic        halted;
  logic [31:0] retire_count;

  hack_cpu_mc dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .inM         (inM),
    .mem_ready   (mem_ready),
    .outM        (outM),
    .writeM      (writeM),
    .readM       (readM),
    .addressM    (addressM),
    .pc          (pc),
    .halted      (halted),
    .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  logic [15:0] rom  [0:63];
  logic [15:0] dmem [0:1023];

  assign instruction = rom[pc[5:0]];
  assign inM         = dmem[addressM[9:0]];

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] memv;
    logic [6:0]  comp;
    int          waits;
    logic [15:0] expv;
  } vec_t;
  vec_t vecs[11];

  int n_checks = 0;
  int n_fail   = 0;
  int cur_wait = 0;
  int wait_left = 0;
  int hs_pending = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int overlap = 0;
  int outm_bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Memory responder: each new request waits cur_wait cycles before mem_ready
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        hs_pending = 0;
        wait_left  = cur_wait;
        mem_ready  = 1'b1;
      end else begin
        if (hs_pending != 0) wait_left = cur_wait;
        if (readM || writeM) begin
          if (wait_left > 0) begin
            mem_ready = 1'b0;
            wait_left--;
          end else begin
            mem_ready = 1'b1;
          end
        end else begin
          mem_ready = 1'b1;
          wait_left = cur_wait;
        end
        hs_pending = ((readM || writeM) && mem_ready) ? 1 : 0;
      end
    end
  end

  // Write scoreboard and strobe monitors, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (readM && writeM) overlap++;
        if (!writeM && outM != 16'h0) outm_bad++;
        if (readM) rd_cycles++;
        if (writeM) wr_cycles++;
        if (writeM && mem_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", addressM, outM);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            checkOutput("write_addr", 32'(addressM), 32'(e.addr));
            checkOutput("write_data", 32'(outM), 32'(e.data));
          end
          dmem[addressM[9:0]] = outM;
        end
      end
    end
  end

  task automatic clearRom();
    for (int k = 0; k < 64; k++) rom[k] = 16'h0000;
  endtask

  task automatic pushWrite(input logic [14:0] addr, input logic [15:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    rd_cycles = 0;
    wr_cycles = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic runToHalt(input int bound, output int cycles);
    cycles = 0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
    end while (!halted && cycles < bound);
    if (!halted) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL halt_timeout: got halted=0 after %0d cycles, expected halted=1", cycles);
    end
  endtask

  task automatic applyStimulus(input int i);
    int cycles;
    int exp_cycles;
    clearRom();
    rom[0] = {1'b0, vecs[i].x[14:0]};
    rom[1] = 16'hEC10;
    rom[2] = {1'b0, vecs[i].y[14:0]};
    rom[3] = {3'b111, vecs[i].comp, 3'b001, 3'b000};
    rom[4] = 16'h0005;
    rom[5] = 16'hEA87;
    dmem[vecs[i].y[9:0]] = vecs[i].memv;
    cur_wait = vecs[i].waits;
    exp_cycles = vecs[i].comp[6] ? (8 + 2 * vecs[i].waits) : (7 + vecs[i].waits);
    exp_q.delete();
    pushWrite(vecs[i].y[14:0], vecs[i].expv);
    applyReset();
    runToHalt(100, cycles);
    checkOutput($sformatf("v%0d_cycles", i), 32'(cycles), 32'(exp_cycles));
    checkOutput($sformatf("v%0d_pc", i), 32'(pc), 32'd5);
    checkOutput($sformatf("v%0d_retire", i), retire_count, 32'd6);
    checkOutput($sformatf("v%0d_pending_writes", i), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cycles;
    reset = 1'b1;
    for (int k = 0; k < 1024; k++) dmem[k] = 16'h0000;
    clearRom();

    vecs[0]  = '{16'h0003, 16'd100, 16'h0000, 7'b0000010, 0, 16'h0067};
    vecs[1]  = '{16'h0005, 16'd200, 16'h0000, 7'b0010011, 1, 16'hFF3D};
    vecs[2]  = '{16'h0F0F, 16'h00FF, 16'h0000, 7'b0000000, 0, 16'h000F};
    vecs[3]  = '{16'h0F00, 16'h00F0, 16'h0000, 7'b0010101, 2, 16'h0FF0};
    vecs[4]  = '{16'h1234, 16'd10,  16'h0000, 7'b0001101, 0, 16'hEDCB};
    vecs[5]  = '{16'h0000, 16'd20,  16'h0000, 7'b0111010, 1, 16'hFFFF};
    vecs[6]  = '{16'h0001, 16'd50,  16'h0000, 7'b0000111, 0, 16'h0031};
    vecs[7]  = '{16'h0002, 16'd300, 16'd40,   7'b1000010, 0, 16'h002A};
    vecs[8]  = '{16'h0000, 16'd301, 16'd0,    7'b1110010, 2, 16'hFFFF};
    vecs[9]  = '{16'h000A, 16'd302, 16'd3,    7'b1010011, 1, 16'h0007};
    vecs[10] = '{16'h0000, 16'd303, 16'd9,    7'b1110111, 0, 16'h000A};

    // Reset values, then a single A-instruction
    rom[0] = 16'h0005;
    cur_wait = 0;
    @(negedge clock);
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_retire", retire_count, 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_readM", 32'(readM), 32'd0);
    checkOutput("rst_writeM", 32'(writeM), 32'd0);
    checkOutput("rst_outM", 32'(outM), 32'd0);
    checkOutput("rst_addressM", 32'(addressM), 32'd0);
    applyReset();
    step(1);
    checkOutput("ainst_addressM", 32'(addressM), 32'd5);
    checkOutput("ainst_pc", 32'(pc), 32'd1);
    checkOutput("ainst_retire", retire_count, 32'd1);

    for (int i = 0; i < 11; i++) applyStimulus(i);

    // Read with three wait states, then store D to observe it
    clearRom();
    rom[0] = 16'h0064; rom[1] = 16'hFDD0; rom[2] = 16'hE308; rom[3] = 16'h0004; rom[4] = 16'hEA87;
    dmem[100] = 16'd41;
    cur_wait = 3;
    exp_q.delete();
    pushWrite(15'd100, 16'd42);
    applyReset();
    runToHalt(100, cycles);
    checkOutput("rdwait_cycles", 32'(cycles), 32'd13);
    checkOutput("rdwait_read_cycles", 32'(rd_cycles), 32'd4);
    checkOutput("rdwait_write_cycles", 32'(wr_cycles), 32'd4);
    checkOutput("rdwait_pc", 32'(pc), 32'd4);
    checkOutput("rdwait_pending", 32'(exp_q.size()), 32'd0);

    // M=D twice: A and D must be untouched by the first store
    clearRom();
    rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'h00C8; rom[3] = 16'hE308;
    rom[4] = 16'hE308; rom[5] = 16'h0006; rom[6] = 16'hEA87;
    cur_wait = 0;
    exp_q.delete();
    pushWrite(15'd200, 16'd7);
    pushWrite(15'd200, 16'd7);
    applyReset();
    runToHalt(100, cycles);
    checkOutput("store_cycles", 32'(cycles), 32'd9);
    checkOutput("store_write_cycles", 32'(wr_cycles), 32'd2);
    checkOutput("store_read_cycles", 32'(rd_cycles), 32'd0);
    checkOutput("store_pending", 32'(exp_q.size()), 32'd0);

    // AM=M+1 then jump through the new A to a self-loop at 10
    clearRom();
    rom[0] = 16'h012C; rom[1] = 16'hFDE8; rom[2] = 16'hEA87; rom[10] = 16'hEA87;
    dmem[300] = 16'd9;
    cur_wait = 1;
    exp_q.delete();
    pushWrite(15'd300, 16'd10);
    applyReset();
    runToHalt(100, cycles);
    checkOutput("rmw_cycles", 32'(cycles), 32'd8);
    checkOutput("rmw_addressM", 32'(addressM), 32'd10);
    checkOutput("rmw_pc", 32'(pc), 32'd10);
    checkOutput("rmw_retire", retire_count, 32'd4);
    checkOutput("rmw_pending", 32'(exp_q.size()), 32'd0);

    // JEQ taken on D=0, JGT not taken on D=-1
    clearRom();
    rom[0] = 16'h0000; rom[1] = 16'hEC10; rom[2] = 16'h000C; rom[3] = 16'hE302;
    rom[12] = 16'hEE90; rom[13] = 16'h0014; rom[14] = 16'hE301; rom[15] = 16'h0010; rom[16] = 16'hEA87;
    cur_wait = 0;
    exp_q.delete();
    applyReset();
    step(4);
    checkOutput("jeq_pc", 32'(pc), 32'd12);
    step(3);
    checkOutput("jgt_pc", 32'(pc), 32'd15);
    runToHalt(20, cycles);
    checkOutput("jmp_halt_pc", 32'(pc), 32'd16);
    step(3);
    checkOutput("halt_hold_pc", 32'(pc), 32'd16);
    checkOutput("halt_hold_retire", retire_count, 32'd9);
    checkOutput("halt_hold_halted", 32'(halted), 32'd1);

    // Halt at pc=3 stays frozen with no strobes
    clearRom();
    rom[2] = 16'h0003; rom[3] = 16'hEA87;
    applyReset();
    runToHalt(20, cycles);
    checkOutput("halt3_cycles", 32'(cycles), 32'd4);
    step(5);
    checkOutput("halt3_pc", 32'(pc), 32'd3);
    checkOutput("halt3_retire", retire_count, 32'd4);
    checkOutput("halt3_strobes", 32'(rd_cycles + wr_cycles), 32'd0);

    // Asynchronous reset in the middle of a stalled read
    clearRom();
    rom[0] = 16'h0064; rom[1] = 16'hFC10;
    cur_wait = 5;
    applyReset();
    step(2);
    checkOutput("midread_readM", 32'(readM), 32'd1);
    checkOutput("midread_pc", 32'(pc), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_readM", 32'(readM), 32'd0);
    checkOutput("async_rst_pc", 32'(pc), 32'd0);
    checkOutput("async_rst_retire", retire_count, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    checkOutput("strobe_overlap", 32'(overlap), 32'd0);
    checkOutput("outM_idle_nonzero", 32'(outm_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_cpu_mc.md
HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 Parameter WIDTH, default 16, data word width; values below 16 are illegal.
REQ-002 Parameter AW, default 15, data and instruction address width.
REQ-003 Parameter CNT_W, default 32, retire counter width.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 instruction  input  WIDTH  word at address pc; combinational ROM, valid in the same cycle.
REQ-007 inM  input  WIDTH  data memory read data; valid when mem_ready=1.
REQ-008 mem_ready  input  1  memory completes the current readM or writeM request.
REQ-009 outM  output  WIDTH  write data.
REQ-010 writeM  output  1  write request.
REQ-011 readM  output  1  read request.
REQ-012 addressM  output  AW  data address, equal to A[AW-1:0].
REQ-013 pc  output  AW  program counter.
REQ-014 halted  output  1  self-loop detected; core frozen.
REQ-015 retire_count  output  CNT_W  number of committed instructions.

Function
REQ-016 Decode: bit WIDTH-1 set means C-instruction; otherwise A-instruction.
REQ-017 C fields: a=[12], c1..c6=[11:6], d1..d3=[5:3] (A, D, M), j1..j3=[2:0]; bits [WIDTH-2:13] are ignored.
REQ-018 A-instruction: A is loaded with instruction[WIDTH-2:0], zero-extended.
REQ-019 ALU: x=D; y=A when a=0, inM when a=1; standard zx/nx/zy/ny/f/no semantics at WIDTH bits; zr and ng derive from the result.
REQ-020 Jump is taken when (j1&ng)|(j2&zr)|(j3&!ng&!zr); target is A[AW-1:0] before commit.
REQ-021 Otherwise the next pc is pc+1, wrapping modulo 2^AW.
REQ-022 Commit: A, D, pc and retire_count (+1, wraps) update together in one edge; nothing else updates them.
REQ-023 FSM state DECODE, A-instruction or C-instruction with a=0 and d3=0: execute and commit in 1 cycle.
REQ-024 FSM state DECODE, a=1: go to READ.
REQ-025 FSM state DECODE, a=0 and d3=1: latch the ALU result into WDATA and go to WRITE.
REQ-026 FSM state READ: readM=1.
REQ-027 READ, mem_ready=1 and d3=0: compute the ALU with y=inM, commit, and go to DECODE.
REQ-028 READ, mem_ready=1 and d3=1: latch the ALU result into WDATA and go to WRITE.
REQ-029 READ, mem_ready=0: hold.
REQ-030 FSM state WRITE: writeM=1, outM=WDATA, addressM=pre-commit A.
REQ-031 WRITE, mem_ready=1: commit and go to DECODE; mem_ready=0: hold with all outputs stable.
REQ-032 Latency with zero wait states: A-instruction and C-instruction without M take 1 cycle; read 2; write 2; read-modify-write 3; each cycle of mem_ready=0 adds one.
REQ-033 mem_ready is ignored in DECODE and HALT.
REQ-034 readM and writeM are never both high.
REQ-035 Outside WRITE, outM is 0.
REQ-036 When a commit takes a jump whose target equals the current pc, the FSM enters HALT.
REQ-037 HALT: halted=1, pc, A and D frozen, no memory strobes, no retires; only reset leaves HALT.

Reset
REQ-038 Reset forces: pc=0, A=0, D=0, WDATA=0, retire_count=0, state=DECODE, halted=0, readM=0, writeM=0.
REQ-039 Reset applies immediately, including mid-READ or mid-WRITE; the in-flight instruction is abandoned uncommitted.

Structure
REQ-040 Shared package hack_pkg: FSM state enum (DECODE, READ, WRITE, HALT), C-field bit positions, jump-bit constants.
REQ-041 The ALU is one combinational sub-module, hack_alu, parametrised by WIDTH.

Verification
REQ-042 Reset, then @5 (0x0005) at pc=0 -> after 1 cycle A=5, pc=1, retire_count=1.
REQ-043 A=100, D=M+1, inM=41, mem_ready low 3 cycles -> readM high 4 cycles, then D=42, pc+1; writeM never asserted.
REQ-044 D=7, A=200, M=D, mem_ready=1 -> writeM high exactly 1 cycle with outM=7, addressM=200; A and D unchanged.
REQ-045 A=300, AM=M+1, inM=9 -> READ then WRITE with outM=10, addressM=300; after commit A=10.
REQ-046 D=0, A=12, D;JEQ -> pc=12; D=0xFFFF, D;JGT -> pc+1.
REQ-047 @3 at pc=2, then 0;JMP at pc=3 -> halted=1, pc stays 3, no strobes; reset asserted mid-READ -> readM drops in the same cycle, pc=0.
